// File: rtl/rr_reg_arbiter_pkg.sv
// ============================================================================
// Module : rr_reg_arbiter_pkg
// Brief  : Shared FSM encodings, default widths and ptr-width helper for the
//          round-robin register arbiter. Optional feature: RR_REG_ARBITER_LOCK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rr_reg_arbiter_pkg;

    localparam int DEF_N         = 4;
    localparam int DEF_W         = 8;
    localparam int DEF_MAX_BURST = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;

    // Never returns 0 so a 1-requester-wide index still gets a real bit.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return (res < 1) ? 1 : res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_reg_arbiter_if.sv
// ============================================================================
// Module : rr_reg_arbiter_if
// Brief  : Requester-side bundle of the shared-register arbiter; the lock
//          vector exists only when RR_REG_ARBITER_LOCK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rr_reg_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
`ifdef RR_REG_ARBITER_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           q_valid;

`ifdef RR_REG_ARBITER_LOCK_EN
    modport master (output req, din, lock, input  gnt, ack, q, q_valid);
    modport slave  (input  req, din, lock, output gnt, ack, q, q_valid);
`else
    modport master (output req, din, input  gnt, ack, q, q_valid);
    modport slave  (input  req, din, output gnt, ack, q, q_valid);
`endif

endinterface

`default_nettype wire

// File: rtl/rr_reg_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker: first set request at or after
//          ptr, wrapping modulo N; returns one-hot winner and its index.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  wire logic [N-1:0]  req,
    input  wire logic [PW-1:0] ptr,
    output logic      [N-1:0]  onehot,
    output logic      [PW-1:0] idx
);

    logic w_found;
    int   w_pos;

    always_comb begin
        onehot  = '0;
        idx     = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(ptr) + k) % N;
            if (!w_found && req[w_pos]) begin
                onehot[w_pos] = 1'b1;
                idx           = PW'(w_pos);
                w_found       = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_reg_arbiter.sv
// ============================================================================
// Module : rr_reg_arbiter
// Brief  : Round-robin owner of one shared W-bit register; grant, write, ack.
//          Macro RR_REG_ARBITER_LOCK_EN enables lock-driven write bursts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_reg_arbiter
    import rr_reg_arbiter_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int W         = DEF_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  wire logic        clk,
    input  wire logic        r,
    rr_reg_arbiter_if.slave  bus
);

    localparam int PW = clog2(N);

    if (N < 2 || N > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_param_check
        $error("rr_reg_arbiter: parameter out of range");
    end

    logic [1:0]    r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_win;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  r_ack;
    logic [W-1:0]  r_q;
    logic          r_q_valid;

    logic [N-1:0]  w_pick_onehot;
    logic [PW-1:0] w_pick_idx;
    logic [PW-1:0] w_ptr_next;
    logic [W-1:0]  w_wdata;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req    (bus.req),
        .ptr    (r_ptr),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx)
    );

    assign w_ptr_next = (r_win == PW'(N - 1)) ? '0 : r_win + 1'b1;
    assign w_wdata    = bus.din[int'(r_win) * W +: W];

`ifdef RR_REG_ARBITER_LOCK_EN
    logic [3:0] r_burst_cnt;
    logic       w_extend;

    // Another write fits in this grant only while the count stays under MAX_BURST.
    assign w_extend = bus.lock[r_win] && (({1'b0, r_burst_cnt} + 5'd1) < 5'(MAX_BURST));
`endif

    always_ff @(posedge clk) begin
        if (r) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_win       <= '0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_q         <= '0;
            r_q_valid   <= 1'b0;
`ifdef RR_REG_ARBITER_LOCK_EN
            r_burst_cnt <= '0;
`endif
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_gnt   <= w_pick_onehot;
                        r_win   <= w_pick_idx;
                        r_state <= ST_GRANT;
                    end else begin
                        r_gnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (bus.req[r_win]) begin
                        r_q       <= w_wdata;
                        r_ack     <= r_gnt;
                        r_q_valid <= 1'b1;
`ifdef RR_REG_ARBITER_LOCK_EN
                        if (w_extend) begin
                            r_burst_cnt <= r_burst_cnt + 4'd1;
                        end else begin
                            r_burst_cnt <= '0;
                            r_ptr       <= w_ptr_next;
                            r_gnt       <= '0;
                            r_state     <= ST_IDLE;
                        end
`else
                        r_ptr     <= w_ptr_next;
                        r_gnt     <= '0;
                        r_state   <= ST_IDLE;
`endif
                    end else begin
                        // Abandoned grant: no write, but the pointer still moves on.
`ifdef RR_REG_ARBITER_LOCK_EN
                        r_burst_cnt <= '0;
`endif
                        r_ptr   <= w_ptr_next;
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.ack     = r_ack;
    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_reg_arbiter.sv
// ============================================================================
// Module : tb_rr_reg_arbiter
// Brief  : Table-driven directed bench for rr_reg_arbiter (N=4, W=8), with
//          hand sequences for din sampling and RR_REG_ARBITER_LOCK_EN bursts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam logic [31:0] DIN_RR = 32'h13121110;
    localparam logic [31:0] DIN_A5 = 32'h13A51110;

    typedef struct {
        logic        r;
        logic [3:0]  req;
        logic [31:0] din;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [7:0]  q;
        logic        qv;
    } vec_t;

    logic clk;
    logic r;
    int   n_vec;
    int   n_bad;
    vec_t tv[24];

    rr_reg_arbiter_if #(.N(N), .W(W)) bus ();

    rr_reg_arbiter #(.N(N), .W(W), .MAX_BURST(4)) dut (
        .clk (clk),
        .r   (r),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rr, input logic [3:0] rq, input logic [31:0] d);
        r       = rr;
        bus.req = rq;
        bus.din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [3:0] g, input logic [3:0] a,
                           input logic [7:0] qq, input logic qv);
        chk({nm, " gnt"},     32'(bus.gnt),     32'(g));
        chk({nm, " ack"},     32'(bus.ack),     32'(a));
        chk({nm, " q"},       32'(bus.q),       32'(qq));
        chk({nm, " q_valid"}, 32'(bus.q_valid), 32'(qv));
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        r       = 1'b1;
        bus.req = '0;
        bus.din = '0;
`ifdef RR_REG_ARBITER_LOCK_EN
        bus.lock = '0;
`endif
        //          r     req    din     gnt    ack    q      qv
        tv[0]  = '{1'b1, 4'hF, DIN_RR, 4'h0, 4'h0, 8'h00, 1'b0};
        tv[1]  = '{1'b1, 4'hF, DIN_RR, 4'h0, 4'h0, 8'h00, 1'b0};
        tv[2]  = '{1'b0, 4'h4, DIN_A5, 4'h4, 4'h0, 8'h00, 1'b0};
        tv[3]  = '{1'b0, 4'h4, DIN_A5, 4'h0, 4'h4, 8'hA5, 1'b1};
        tv[4]  = '{1'b0, 4'h0, DIN_A5, 4'h0, 4'h0, 8'hA5, 1'b1};
        tv[5]  = '{1'b1, 4'hF, DIN_RR, 4'h0, 4'h0, 8'h00, 1'b0};
        tv[6]  = '{1'b0, 4'hF, DIN_RR, 4'h1, 4'h0, 8'h00, 1'b0};
        tv[7]  = '{1'b0, 4'hF, DIN_RR, 4'h0, 4'h1, 8'h10, 1'b1};
        tv[8]  = '{1'b0, 4'hF, DIN_RR, 4'h2, 4'h0, 8'h10, 1'b1};
        tv[9]  = '{1'b0, 4'hF, DIN_RR, 4'h0, 4'h2, 8'h11, 1'b1};
        tv[10] = '{1'b0, 4'hF, DIN_RR, 4'h4, 4'h0, 8'h11, 1'b1};
        tv[11] = '{1'b0, 4'hF, DIN_RR, 4'h0, 4'h4, 8'h12, 1'b1};
        tv[12] = '{1'b0, 4'hF, DIN_RR, 4'h8, 4'h0, 8'h12, 1'b1};
        tv[13] = '{1'b0, 4'hF, DIN_RR, 4'h0, 4'h8, 8'h13, 1'b1};
        tv[14] = '{1'b0, 4'hF, DIN_RR, 4'h1, 4'h0, 8'h13, 1'b1};
        tv[15] = '{1'b0, 4'hF, DIN_RR, 4'h0, 4'h1, 8'h10, 1'b1};
        // abandon: ptr=1, requester 1 drops out while granted
        tv[16] = '{1'b0, 4'h6, DIN_RR, 4'h2, 4'h0, 8'h10, 1'b1};
        tv[17] = '{1'b0, 4'h4, DIN_RR, 4'h0, 4'h0, 8'h10, 1'b1};
        tv[18] = '{1'b0, 4'h6, DIN_RR, 4'h4, 4'h0, 8'h10, 1'b1};
        tv[19] = '{1'b0, 4'h6, DIN_RR, 4'h0, 4'h4, 8'h12, 1'b1};
        // reset mid-grant, then ptr must restart at 0
        tv[20] = '{1'b0, 4'h8, DIN_RR, 4'h8, 4'h0, 8'h12, 1'b1};
        tv[21] = '{1'b1, 4'h8, DIN_RR, 4'h0, 4'h0, 8'h00, 1'b0};
        tv[22] = '{1'b0, 4'hA, DIN_RR, 4'h2, 4'h0, 8'h00, 1'b0};
        tv[23] = '{1'b0, 4'hA, DIN_RR, 4'h0, 4'h2, 8'h11, 1'b1};

        for (int i = 0; i < 24; i++) begin
            step(tv[i].r, tv[i].req, tv[i].din);
            chk_out($sformatf("v%0d", i), tv[i].gnt, tv[i].ack, tv[i].q, tv[i].qv);
        end

        // ptr=2: din[winner] changes between grant and commit; commit edge value wins
        step(1'b0, 4'h4, DIN_RR);
        chk_out("dinsamp grant", 4'h4, 4'h0, 8'h11, 1'b1);
        step(1'b0, 4'h4, 32'hFF5C1110);
        chk_out("dinsamp commit", 4'h0, 4'h4, 8'h5C, 1'b1);
        step(1'b0, 4'h0, DIN_RR);
        chk_out("dinsamp idle", 4'h0, 4'h0, 8'h5C, 1'b1);

        // ptr=3 now, requesters 0 and 3 pending
`ifdef RR_REG_ARBITER_LOCK_EN
        bus.lock = 4'h8;
        step(1'b0, 4'h9, DIN_RR);
        chk_out("lock grant", 4'h8, 4'h0, 8'h5C, 1'b1);
        for (int b = 0; b < 3; b++) begin
            step(1'b0, 4'h9, DIN_RR);
            chk_out($sformatf("lock burst%0d", b), 4'h8, 4'h8, 8'h13, 1'b1);
        end
        step(1'b0, 4'h9, DIN_RR);
        chk_out("lock release", 4'h0, 4'h8, 8'h13, 1'b1);
        step(1'b0, 4'h9, DIN_RR);
        chk_out("lock next", 4'h1, 4'h0, 8'h13, 1'b1);
        bus.lock = 4'h0;
`else
        step(1'b0, 4'h9, DIN_RR);
        chk_out("single grant", 4'h8, 4'h0, 8'h5C, 1'b1);
        step(1'b0, 4'h9, DIN_RR);
        chk_out("single commit", 4'h0, 4'h8, 8'h13, 1'b1);
        step(1'b0, 4'h9, DIN_RR);
        chk_out("single wrap", 4'h1, 4'h0, 8'h13, 1'b1);
`endif
        step(1'b0, 4'h9, DIN_RR);
        chk_out("wrap commit", 4'h0, 4'h1, 8'h10, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
